// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 8-bit unsigned shift-add multiplier sequenced on a shared combinational ALU.
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   start_i, op_a_i, op_b_i   request and operands, sampled on the accept edge in IDLE
//   busy_o, done_o, product_o handshake and low byte of op_a * (op_b mod 2^ITERATIONS)
//   alu_*_o / alu_out_i       drive and result of the shared ALU (00 add, 01 andb, 10 xor, 11 shift)
// Optional: define ALU_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module alu_mul_sequencer #(
    parameter int ITERATIONS = 8
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic [7:0] op_a_i,
    input  logic [7:0] op_b_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] product_o,
    output logic [7:0] alu_in1_o,
    output logic [7:0] alu_in2_o,
    output logic [1:0] alu_op_o,
    output logic       alu_sub_o,
    output logic       alu_branch_o,
    output logic [1:0] alu_branch_sel_o,
    output logic       alu_shift_left_o,
    input  logic [7:0] alu_out_i
);
    typedef enum logic [2:0] {S_IDLE, S_AND, S_ADD, S_SHL, S_SHR, S_DONE} state_e;
    localparam logic [2:0] LAST = 3'(ITERATIONS - 1);
    state_e state_q, state_d;
    logic [7:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, part_q, part_d, product_q, product_d;
    logic [2:0] cnt_q, cnt_d;
    logic       zero_exit;
`ifdef ALU_MUL_EARLY_EXIT_EN
    assign zero_exit = alu_out_i == 8'd0;
`else
    assign zero_exit = 1'b0;
`endif
    assign alu_sub_o        = 1'b0;
    assign alu_branch_o     = 1'b0;
    assign alu_branch_sel_o = 2'b00;
    assign product_o        = product_q;
    assign busy_o = state_q == S_AND || state_q == S_ADD || state_q == S_SHL || state_q == S_SHR;
    assign done_o = state_q == S_DONE;
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            part_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            part_q    <= part_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
    always_comb begin
        state_d          = state_q;
        mcand_d          = mcand_q;
        mplier_d         = mplier_q;
        acc_d            = acc_q;
        part_d           = part_q;
        cnt_d            = cnt_q;
        product_d        = product_q;
        alu_in1_o        = 8'd0;
        alu_in2_o        = 8'd0;
        alu_op_o         = 2'b00;
        alu_shift_left_o = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                mcand_d  = op_a_i;
                mplier_d = op_b_i;
                acc_d    = 8'd0;
                cnt_d    = 3'd0;
                state_d  = S_AND;
            end
            // andb masks operand 1 with bit 0 of operand 2: partial = mcand or 0
            S_AND: begin
                alu_in1_o = mcand_q;
                alu_in2_o = mplier_q;
                alu_op_o  = 2'b01;
                part_d    = alu_out_i;
                state_d   = S_ADD;
            end
            S_ADD: begin
                alu_in1_o = acc_q;
                alu_in2_o = part_q;
                acc_d     = alu_out_i;
                state_d   = S_SHL;
            end
            S_SHL: begin
                alu_in1_o        = mcand_q;
                alu_in2_o        = 8'd1;
                alu_op_o         = 2'b11;
                alu_shift_left_o = 1'b1;
                mcand_d          = alu_out_i;
                state_d          = S_SHR;
            end
            S_SHR: begin
                alu_in1_o = mplier_q;
                alu_in2_o = 8'd1;
                alu_op_o  = 2'b11;
                mplier_d  = alu_out_i;
                if (cnt_q == LAST || zero_exit) begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = S_AND;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed bench for alu_mul_sequencer with a behavioural ALU model.
module tb_alu_mul_sequencer;
    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic       busy, done, alu_sub, alu_branch, alu_shift_left;
    logic [7:0] product, alu_in1, alu_in2, alu_out;
    logic [1:0] alu_op, alu_branch_sel;
    int checks = 0, errors = 0;
    logic [7:0] last_prod = '0;
    always #5 clk = ~clk;
    alu_mul_sequencer dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
        .busy_o(busy), .done_o(done), .product_o(product),
        .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_op_o(alu_op), .alu_sub_o(alu_sub),
        .alu_branch_o(alu_branch), .alu_branch_sel_o(alu_branch_sel),
        .alu_shift_left_o(alu_shift_left), .alu_out_i(alu_out)
    );
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_sub ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
            2'b01:   alu_out = alu_in1 & {8{alu_in2[0]}};
            2'b10:   alu_out = alu_in1 ^ alu_in2;
            default: alu_out = alu_shift_left ? alu_in1 << alu_in2[2:0] : alu_in1 >> alu_in2[2:0];
        endcase
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int exp_lat(input logic [7:0] b);
        int n;
`ifdef ALU_MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`else
        n = 8;
`endif
        return 4 * n + 1;
    endfunction
    task automatic idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_alu"}, {alu_in1, alu_in2, alu_op, alu_shift_left}, 0);
        chk({tag, "_ctl0"}, {alu_sub, alu_branch, alu_branch_sel}, 0);
    endtask
    // Entered at #1 after an edge with the DUT in IDLE; the next edge is the accept edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp, input bit hold);
        int lat;
        int ph;
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        op_a = ~a;
        op_b = ~b;
        lat = exp_lat(b);
        chk("prod_held", product, last_prod);
        for (int c = 1; c < lat; c++) begin
            ph = (c - 1) % 4;
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("alu_op", alu_op, ph == 0 ? 1 : ph == 1 ? 0 : 3);
            chk("shift_left", alu_shift_left, ph == 2 ? 1 : 0);
            chk("ctl0", {alu_sub, alu_branch, alu_branch_sel}, 0);
            @(posedge clk); #1;
        end
        chk("done", done, 1);
        chk("product", product, exp);
        idle_outputs("done_cyc");
        last_prod = exp;
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("prod_keep", product, exp);
    endtask
    initial begin
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        idle_outputs("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd13, 8'd11, 8'h8F, 1'b0);
        run_op(8'd25, 8'd20, 8'hF4, 1'b0);
        run_op(8'd255, 8'd255, 8'h01, 1'b0);
        run_op(8'd77, 8'd0, 8'h00, 1'b0);
        run_op(8'd6, 8'd1, 8'h06, 1'b0);
        run_op(8'd6, 8'h80, 8'h00, 1'b0);
        run_op(8'd3, 8'd2, 8'h06, 1'b1);
        run_op(8'd5, 8'd4, 8'h14, 1'b0);
        run_op(8'd7, 8'd9, 8'h3F, 1'b0);
        op_a = 8'd7;
        op_b = 8'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_abort_busy", busy, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        reset_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (done || busy) seen++;
            end
            chk("abort_no_done", seen, 0);
        end
        chk("abort_prod_stay", product, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
